hash_key_packer: RTL

- Upstream feeder of the Jenkins lookup3 hash pipeline.
- Accepts a memcache key as a byte stream, with the key length taken from the protocol header on the first byte.
- Packs the bytes into 12-byte blocks (k0,k1,k2) and tags each block with the remaining-byte count w, in the same semantics as the hash round input.
- Presents one block at a time on a valid/ready interface to the hash round/collector logic.

---
 rtl/hash_pkg.sv | 23 ++
 rtl/hash_key_packer_if.sv | 31 +++
 rtl/hash_lane_reg.sv | 50 +++++
 rtl/hash_key_packer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// Shared definitions for the lookup3 key packer: block geometry, defaults, FSM codes and
// the block record presented to the hash round.
package hash_pkg;

  localparam int unsigned BLOCK_BYTES     = 12;
  localparam int unsigned DEFAULT_MAX_LEN = 250;
  localparam logic [31:0] JHASH_INIT      = 32'hDEADBEEF;

  typedef logic [1:0] pk_state_t;
  localparam pk_state_t ST_IDLE = 2'd0;
  localparam pk_state_t ST_FILL = 2'd1;
  localparam pk_state_t ST_HOLD = 2'd2;

  typedef struct packed {
    logic [31:0] k0;
    logic [31:0] k1;
    logic [31:0] k2;
    logic [7:0]  w;
    logic        first;
    logic        last;
  } hash_block_t;

endpackage

// File: rtl/hash_key_packer_if.sv
// Byte-stream input, block output and error pulses of the key packer.
// slave: the packer; master: whoever feeds bytes and consumes blocks.
interface hash_key_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sof;
  logic [7:0]  in_len;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_k0;
  logic [31:0] out_k1;
  logic [31:0] out_k2;
  logic [7:0]  out_w;
  logic        out_first;
  logic        out_last;
  logic        err_len;
  logic        err_abort;

  modport slave (
    input  in_valid, in_data, in_sof, in_len, out_ready,
    output in_ready, out_valid, out_k0, out_k1, out_k2, out_w, out_first, out_last,
           err_len, err_abort
  );

  modport master (
    output in_valid, in_data, in_sof, in_len, out_ready,
    input  in_ready, out_valid, out_k0, out_k1, out_k2, out_w, out_first, out_last,
           err_len, err_abort
  );
endinterface

// File: rtl/hash_lane_reg.sv
// 12-byte block register with indexed byte write and clear; clear and write in the same
// cycle leave only the written byte. HASH_PACK_BSWAP_EN selects big-endian word lanes.
module hash_lane_reg
  import hash_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_we,
  input  logic [3:0]  i_idx,
  input  logic [7:0]  i_data,
  output logic [31:0] o_k0,
  output logic [31:0] o_k1,
  output logic [31:0] o_k2
);

  logic [BLOCK_BYTES-1:0][7:0] r_bytes;
  logic [2:0][31:0]            w_k;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bytes <= '0;
    end else begin
      if (i_clr) begin
        r_bytes <= '0;
      end
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (i_we && (i_idx == 4'(i))) begin
          r_bytes[i] <= i_data;
        end
      end
    end
  end

  always_comb begin
    w_k = '0;
    for (int n = 0; n < 3; n++) begin
`ifdef HASH_PACK_BSWAP_EN
      w_k[n] = {r_bytes[4*n], r_bytes[4*n+1], r_bytes[4*n+2], r_bytes[4*n+3]};
`else
      w_k[n] = {r_bytes[4*n+3], r_bytes[4*n+2], r_bytes[4*n+1], r_bytes[4*n]};
`endif
    end
  end

  assign o_k0 = w_k[0];
  assign o_k1 = w_k[1];
  assign o_k2 = w_k[2];

endmodule

// File: rtl/hash_key_packer.sv
// Packs a memcache key byte stream into 12-byte lookup3 blocks tagged with remaining length.
// Build option HASH_PACK_BSWAP_EN switches to big-endian lanes (see hash_lane_reg).
module hash_key_packer
  import hash_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN
) (
  input logic              CLK,
  input logic              RST,
  hash_key_packer_if.slave bus
);

  pk_state_t   r_state, w_state;
  logic [3:0]  r_idx, w_idx;
  logic [7:0]  r_rem, w_rem;
  logic        r_first, w_first;
  logic        r_err_len, w_err_len;
  logic        r_err_abort, w_err_abort;
  logic        w_clr, w_we;
  logic [3:0]  w_widx;
  logic        w_in_fire, w_out_fire, w_len_ok, w_close, w_hold;
  logic [31:0] w_k0, w_k1, w_k2;
  hash_block_t w_blk;

  assign w_hold     = (r_state == ST_HOLD);
  assign w_in_fire  = bus.in_valid && !w_hold;
  assign w_out_fire = w_hold && bus.out_ready;
  assign w_len_ok   = (bus.in_len != 8'd0) && (32'(bus.in_len) <= MAX_LEN);
  // Block ends on a full block or on the key's final byte.
  assign w_close    = (r_idx == 4'(BLOCK_BYTES - 1)) || ((8'(r_idx) + 8'd1) == r_rem);

  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_rem       = r_rem;
    w_first     = r_first;
    w_err_len   = 1'b0;
    w_err_abort = 1'b0;
    w_clr       = 1'b0;
    w_we        = 1'b0;
    w_widx      = r_idx;
    case (r_state)
      ST_IDLE, ST_FILL: begin
        if (w_in_fire) begin
          if (bus.in_sof) begin
            // A new key in FILL throws away the partial block before restarting.
            w_err_abort = (r_state == ST_FILL);
            w_clr       = (r_state == ST_FILL);
            w_idx       = 4'd0;
            if (!w_len_ok) begin
              w_err_len = 1'b1;
              w_state   = ST_IDLE;
            end else begin
              w_rem   = bus.in_len;
              w_first = 1'b1;
              w_we    = 1'b1;
              w_widx  = 4'd0;
              if (bus.in_len == 8'd1) begin
                w_state = ST_HOLD;
              end else begin
                w_idx   = 4'd1;
                w_state = ST_FILL;
              end
            end
          end else if (r_state == ST_FILL) begin
            w_we   = 1'b1;
            w_widx = r_idx;
            if (w_close) begin
              w_idx   = 4'd0;
              w_state = ST_HOLD;
            end else begin
              w_idx = r_idx + 4'd1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (w_out_fire) begin
          w_first = 1'b0;
          w_rem   = (r_rem > 8'(BLOCK_BYTES)) ? (r_rem - 8'(BLOCK_BYTES)) : 8'd0;
          w_clr   = 1'b1;
          w_idx   = 4'd0;
          w_state = (r_rem <= 8'(BLOCK_BYTES)) ? ST_IDLE : ST_FILL;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_rem       <= '0;
      r_first     <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_abort <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_rem       <= w_rem;
      r_first     <= w_first;
      r_err_len   <= w_err_len;
      r_err_abort <= w_err_abort;
    end
  end

  hash_lane_reg u_lanes (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_clr  (w_clr),
    .i_we   (w_we),
    .i_idx  (w_widx),
    .i_data (bus.in_data),
    .o_k0   (w_k0),
    .o_k1   (w_k1),
    .o_k2   (w_k2)
  );

  always_comb begin
    w_blk       = '0;
    w_blk.k0    = w_k0;
    w_blk.k1    = w_k1;
    w_blk.k2    = w_k2;
    w_blk.w     = w_hold ? r_rem : 8'd0;
    w_blk.first = w_hold && r_first;
    w_blk.last  = w_hold && (r_rem <= 8'(BLOCK_BYTES));
  end

  assign bus.in_ready  = !w_hold;
  assign bus.out_valid = w_hold;
  assign bus.out_k0    = w_blk.k0;
  assign bus.out_k1    = w_blk.k1;
  assign bus.out_k2    = w_blk.k2;
  assign bus.out_w     = w_blk.w;
  assign bus.out_first = w_blk.first;
  assign bus.out_last  = w_blk.last;
  assign bus.err_len   = r_err_len;
  assign bus.err_abort = r_err_abort;

endmodule
